uart_alu_ctrl: RTL and testbench
================================

# uart_alu_ctrl

Packet sequencer between the UART byte streams and the 32-bit ALU inside `top`. It parses framed command packets from the RX byte stream and reduces the operands through the external ALU with a valid/ready handshake. It then serializes the 32-bit result, or echoes the payload, onto the TX byte stream. It is the only block that drives the ALU and the only producer feeding the TX serializer.

## Interface
- `TIMEOUT_CYC`, 3_225_600: inter-byte idle limit, 100 ms at 32.256 MHz. 0 disables the timeout.
- `clk` in 1: system clock (PLL output).
- `rst` in 1: asynchronous, active-low reset.
- `rx_data_i` in 8: received byte.
- `rx_valid_i` in 1: received byte valid.
- `rx_ready_o` out 1: controller accepts the byte this cycle.
- `tx_data_o` out 8: byte to transmit.
- `tx_valid_o` out 1: TX byte valid.
- `tx_ready_i` in 1: serializer accepts the byte.
- `alu_op_o` out 2: 0 = add, 1 = mul, 2 = div (unsigned).
- `alu_a_o`, `alu_b_o` out 32: operands (accumulator, new operand).
- `alu_valid_o` out 1: request.
- `alu_ready_i` in 1: request accepted.
- `alu_res_i` in 32: result.
- `alu_res_valid_i` in 1: result valid, single-cycle pulse.
- `err_o` out 1: one-cycle pulse on framing error or timeout.

## Operation
- Packet format: opcode byte, reserved byte, then len LSB and len MSB. `len` is the total byte count including the 4-byte header. Payload follows. Operands are 32-bit little-endian.
- Opcodes:
  - 0xEC = echo
  - 0xAD = add
  - 0x88 = mul
  - 0xD1 = div
- States: HDR0 → HDR1 → HDR2 → HDR3, then one of the following.
  - Arithmetic path: OPND → (ALU_REQ → ALU_WAIT → OPND)* → SEND → HDR0.
  - Echo path: ECHO → HDR0.
  - Error path: DRAIN → HDR0.
- A 16-bit `remaining` counter is loaded with len−4 at HDR3 and decremented on every accepted payload byte.
- Arithmetic rules:
  - Requires len−4 ≥ 8 and (len−4) mod 4 = 0.
  - The first operand loads the accumulator directly, with no ALU call.
  - Each later operand issues one ALU request with acc op operand. The result overwrites acc.
  - After the last ALU result, SEND emits acc as 4 bytes, LSB first.
- Echo: len ≥ 4. Each payload byte is forwarded unchanged. len = 4 produces no TX bytes.
- Framing error (unknown opcode, or illegal arithmetic length):
  - `err_o` pulses in the cycle after the len MSB is accepted.
  - DRAIN consumes len−4 bytes and emits nothing.
- Reserved byte is ignored.
- Division by zero is not detected here; the ALU result is passed through as returned.
- Timeout:
  - A counter runs in every state except HDR0, ALU_WAIT and SEND.
  - It clears on each accepted RX byte.
  - Reaching TIMEOUT_CYC pulses `err_o`, discards the packet and returns to HDR0.
- Reset (any state, asynchronous): aborts the packet immediately. Acc and counters are cleared and the state returns to HDR0.

## Timing
- Reset values: `rx_ready_o` = 1 (combinational, HDR0), `tx_valid_o` = 0, `tx_data_o` = 0, `alu_valid_o` = 0, operands = 0, `alu_op_o` = 0, `err_o` = 0.
- `rx_ready_o` is combinational from state:
  - 1 in HDR0–HDR3, OPND and DRAIN.
  - In ECHO: `!tx_valid_o || tx_ready_i`.
  - 0 in ALU_REQ, ALU_WAIT and SEND.
- A byte transfers when valid && ready in the same rising edge.
- `tx_valid_o` and `tx_data_o` are registered. Once asserted they hold unchanged until `tx_ready_i`.
- Echo latency is 1 cycle from RX accept to `tx_valid_o`. Full throughput is kept under no backpressure.
- `alu_valid_o` and operands are registered. They rise the cycle after the 4th operand byte is accepted and are held stable until `alu_ready_i`. They drop in the cycle after handshake.
- `alu_res_valid_i` is only sampled in ALU_WAIT. Acc is updated on that edge.
- SEND begins the cycle after the final result is captured and takes at least 4 cycles.
- The last TX byte is accepted in the same cycle the state returns to HDR0. The next header byte is accepted on the following cycle.

## Structure
- Package `uart_alu_pkg`:
  - Opcode constants (OP_ECHO, OP_ADD, OP_MUL, OP_DIV).
  - `alu_op_e` enum.
  - `state_e` enum.
  - Header size constant (4).
- Sub-module `uart_alu_timeout`: loadable down-counter with clear and expire outputs. It is the only natural split; the rest is one FSM plus datapath registers.

## Test plan
- Add: RX AD 00 0C 00 01 00 00 00 02 00 00 00 → one ALU request (op 0, a = 1, b = 2). With ALU returning 3, TX 03 00 00 00.
- Mul chain: 88 00 10 00 with operands 2, 3, 4 → two ALU requests. Final TX 18 00 00 00. ALU `alu_ready_i` delayed 5 cycles → operands held stable.
- Echo: EC 00 07 00 41 42 43 with `tx_ready_i` low for 10 cycles after the first byte → TX 41 42 43 in order, with no drops and RX stalled.
- Errors:
  - Opcode 55, len 0x0008 → `err_o` pulse, 4 payload bytes drained, no TX. The following add packet is processed correctly.
  - Add with len 0x000A → same drain behavior.
- Timeout (TIMEOUT_CYC = 50): send AD 00 then idle 50 cycles → `err_o` pulse, state HDR0. The following echo packet works.
- Reset low during ALU_WAIT → `alu_valid_o`, `tx_valid_o` = 0 immediately. After release, a fresh add packet yields the correct result.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// Shared opcodes, ALU operation encoding and sequencer states for the
// UART command/ALU packet sequencer.
package uart_alu_pkg;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hAD;
    localparam logic [7:0] OP_MUL  = 8'h88;
    localparam logic [7:0] OP_DIV  = 8'hD1;

    localparam int HDR_BYTES = 4;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_MUL = 2'd1,
        ALU_DIV = 2'd2
    } alu_op_e;

    typedef enum logic [3:0] {
        HDR0, HDR1, HDR2, HDR3,
        OPND, ALU_REQ, ALU_WAIT, SEND,
        ECHO, DRAIN
    } state_e;

    function automatic alu_op_e opcode_to_alu(input logic [7:0] opc);
        case (opc)
            OP_MUL:  return ALU_MUL;
            OP_DIV:  return ALU_DIV;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/uart_alu_timeout.sv
// Inter-byte idle watchdog: reloads on clear or while stopped, counts down
// while running and flags expiry on the last cycle. TIMEOUT_CYC = 0 disables it.
module uart_alu_timeout #(
    parameter int unsigned TIMEOUT_CYC = 3_225_600
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expire
);

    logic [31:0] cnt;

    assign expire = (TIMEOUT_CYC != 0) && run && !clear && (cnt == 32'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= TIMEOUT_CYC;
        end else if (clear || !run || expire) begin
            cnt <= TIMEOUT_CYC;
        end else begin
            cnt <= cnt - 32'd1;
        end
    end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Packet sequencer: parses RX command packets, folds operands through the
// external ALU and streams the result (or an echo of the payload) to TX.
module uart_alu_ctrl
    import uart_alu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 3_225_600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [1:0]  alu_op_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic        alu_valid_o,
    input  logic        alu_ready_i,
    input  logic [31:0] alu_res_i,
    input  logic        alu_res_valid_i,
    output logic        err_o
);

    state_e      state;
    alu_op_e     alu_op;
    logic [7:0]  opcode;
    logic [7:0]  len_lo;
    logic [15:0] remaining;
    logic [15:0] len_full;
    logic [15:0] plen;
    logic [23:0] opnd;
    logic [31:0] opnd_next;
    logic [31:0] acc;
    logic [2:0]  byte_cnt;
    logic        first_opnd;
    logic        rx_accept;
    logic        timer_run;
    logic        timeout;
    logic        arith_ok;

    assign len_full  = {rx_data_i, len_lo};
    assign plen      = len_full - 16'(HDR_BYTES);
    // At least two operands (12 bytes with header) and whole 32-bit words.
    assign arith_ok  = (len_full >= 16'd12) && (len_full[1:0] == 2'b00);
    assign opnd_next = {rx_data_i, opnd};
    assign alu_op_o  = alu_op;
    assign rx_accept = rx_valid_i && rx_ready_o;
    assign timer_run = !(state inside {HDR0, ALU_WAIT, SEND});

    // In ECHO the last payload byte must not let a header byte slip in
    // while its TX copy is still waiting.
    always_comb begin
        rx_ready_o = 1'b0;
        case (state)
            HDR0, HDR1, HDR2, HDR3, OPND, DRAIN: rx_ready_o = 1'b1;
            ECHO:    rx_ready_o = (remaining != 16'd0) && (!tx_valid_o || tx_ready_i);
            default: rx_ready_o = 1'b0;
        endcase
    end

    uart_alu_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .run    (timer_run),
        .clear  (rx_accept),
        .expire (timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= HDR0;
            alu_op      <= ALU_ADD;
            opcode      <= 8'h00;
            len_lo      <= 8'h00;
            remaining   <= 16'd0;
            opnd        <= 24'd0;
            acc         <= 32'd0;
            byte_cnt    <= 3'd0;
            first_opnd  <= 1'b0;
            tx_data_o   <= 8'h00;
            tx_valid_o  <= 1'b0;
            alu_a_o     <= 32'd0;
            alu_b_o     <= 32'd0;
            alu_valid_o <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            err_o <= 1'b0;
            if (tx_valid_o && tx_ready_i)
                tx_valid_o <= 1'b0;

            if (timeout) begin
                state       <= HDR0;
                err_o       <= 1'b1;
                alu_valid_o <= 1'b0;
            end else begin
                case (state)
                    HDR0: if (rx_accept) begin
                        opcode <= rx_data_i;
                        state  <= HDR1;
                    end
                    HDR1: if (rx_accept) state <= HDR2;
                    HDR2: if (rx_accept) begin
                        len_lo <= rx_data_i;
                        state  <= HDR3;
                    end
                    HDR3: if (rx_accept) begin
                        byte_cnt   <= 3'd0;
                        first_opnd <= 1'b1;
                        remaining  <= (len_full < 16'(HDR_BYTES)) ? 16'd0 : plen;
                        if (opcode == OP_ECHO && len_full >= 16'(HDR_BYTES)) begin
                            state <= (plen == 16'd0) ? HDR0 : ECHO;
                        end else if ((opcode inside {OP_ADD, OP_MUL, OP_DIV}) && arith_ok) begin
                            alu_op <= opcode_to_alu(opcode);
                            state  <= OPND;
                        end else begin
                            err_o <= 1'b1;
                            state <= (len_full <= 16'(HDR_BYTES)) ? HDR0 : DRAIN;
                        end
                    end
                    OPND: if (rx_accept) begin
                        opnd      <= opnd_next[31:8];
                        remaining <= remaining - 16'd1;
                        byte_cnt  <= byte_cnt + 3'd1;
                        if (byte_cnt == 3'd3) begin
                            byte_cnt <= 3'd0;
                            if (first_opnd) begin
                                acc        <= opnd_next;
                                first_opnd <= 1'b0;
                            end else begin
                                alu_a_o     <= acc;
                                alu_b_o     <= opnd_next;
                                alu_valid_o <= 1'b1;
                                state       <= ALU_REQ;
                            end
                        end
                    end
                    ALU_REQ: if (alu_ready_i) begin
                        alu_valid_o <= 1'b0;
                        state       <= ALU_WAIT;
                    end
                    ALU_WAIT: if (alu_res_valid_i) begin
                        acc      <= alu_res_i;
                        byte_cnt <= 3'd0;
                        state    <= (remaining == 16'd0) ? SEND : OPND;
                    end
                    // acc is consumed LSB first by shifting; it is reloaded per packet.
                    SEND: if (!tx_valid_o || tx_ready_i) begin
                        if (byte_cnt == 3'd4) begin
                            state <= HDR0;
                        end else begin
                            tx_valid_o <= 1'b1;
                            tx_data_o  <= acc[7:0];
                            acc        <= {8'h00, acc[31:8]};
                            byte_cnt   <= byte_cnt + 3'd1;
                        end
                    end
                    ECHO: begin
                        if (rx_accept) begin
                            tx_valid_o <= 1'b1;
                            tx_data_o  <= rx_data_i;
                            remaining  <= remaining - 16'd1;
                        end else if (remaining == 16'd0 && (!tx_valid_o || tx_ready_i)) begin
                            state <= HDR0;
                        end
                    end
                    DRAIN: if (rx_accept) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) state <= HDR0;
                    end
                    default: state <= HDR0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl: scoreboarded TX bytes and ALU requests,
// a behavioural ALU with configurable handshake/result latency.
module tb_uart_alu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [1:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_valid;
    logic        alu_ready;
    logic [31:0] alu_res;
    logic        alu_res_valid;
    logic        err;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } alu_req_t;

    int total = 0;
    int passed = 0;
    int err_cnt = 0;
    int alu_hs_cnt = 0;
    int alu_delay = 0;
    int alu_res_delay = 2;

    alu_req_t    exp_alu_q[$];
    logic [7:0]  exp_tx_q[$];
    logic [31:0] opv[4];

    always #5 clk = ~clk;

    uart_alu_ctrl #(.TIMEOUT_CYC(50)) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_data_i       (rx_data),
        .rx_valid_i      (rx_valid),
        .rx_ready_o      (rx_ready),
        .tx_data_o       (tx_data),
        .tx_valid_o      (tx_valid),
        .tx_ready_i      (tx_ready),
        .alu_op_o        (alu_op),
        .alu_a_o         (alu_a),
        .alu_b_o         (alu_b),
        .alu_valid_o     (alu_valid),
        .alu_ready_i     (alu_ready),
        .alu_res_i       (alu_res),
        .alu_res_valid_i (alu_res_valid),
        .err_o           (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    function automatic logic [31:0] alu_f(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a * b;
            2'd2:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return 32'd0;
        endcase
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (rx_ready) break;
        end
        check("rx_accept", 32'(rx_ready), 1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] opc, input logic [15:0] len);
        send_byte(opc);
        send_byte(8'h00);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
    endtask

    // Build expectations from opv[0..n-1], then stream the packet.
    task automatic run_arith(input logic [7:0] opc, input logic [1:0] op, input int n);
        logic [31:0] acc;
        alu_req_t    r;
        acc = opv[0];
        for (int i = 1; i < n; i++) begin
            r.op = op; r.a = acc; r.b = opv[i];
            exp_alu_q.push_back(r);
            acc = alu_f(op, acc, opv[i]);
        end
        for (int j = 0; j < 4; j++) exp_tx_q.push_back(acc[8*j +: 8]);
        send_hdr(opc, 16'(4 + 4 * n));
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 4; j++) send_byte(opv[i][8*j +: 8]);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((exp_tx_q.size() != 0 || exp_alu_q.size() != 0) && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("sb_tx_drained", 32'(exp_tx_q.size()), 0);
        check("sb_alu_drained", 32'(exp_alu_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    // TX scoreboard, stall-hold check and error pulse counter.
    logic       hold_pend = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic       err_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            hold_pend = 1'b0;
            err_prev  = 1'b0;
        end else begin
            if (hold_pend) begin
                check("tx_hold_valid", 32'(tx_valid), 1);
                check("tx_hold_data", 32'(tx_data), 32'(hold_data));
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx_q.size() == 0) check("tx_unexpected", 32'(exp_tx_q.size()), 1);
                else check("tx_byte", 32'(tx_data), 32'(exp_tx_q.pop_front()));
            end
            hold_pend = tx_valid && !tx_ready;
            hold_data = tx_data;
            if (err) begin
                err_cnt++;
                check("err_single_cycle", 32'(err_prev), 0);
            end
            err_prev = err;
        end
    end

    // Behavioural ALU.
    initial begin
        alu_req_t    r;
        logic [31:0] a0, b0;
        logic [1:0]  op0;
        bit          aborted;
        alu_ready     = 1'b0;
        alu_res_valid = 1'b0;
        alu_res       = 32'd0;
        forever begin
            @(negedge clk);
            if (rst && alu_valid) begin
                op0 = alu_op; a0 = alu_a; b0 = alu_b;
                if (exp_alu_q.size() == 0) begin
                    check("alu_unexpected", 32'(exp_alu_q.size()), 1);
                end else begin
                    r = exp_alu_q.pop_front();
                    check("alu_op", 32'(op0), 32'(r.op));
                    check("alu_a", a0, r.a);
                    check("alu_b", b0, r.b);
                end
                for (int d = 0; d < alu_delay; d++) begin
                    @(negedge clk);
                    check("alu_hold_valid", 32'(alu_valid), 1);
                    check("alu_hold_a", alu_a, a0);
                    check("alu_hold_b", alu_b, b0);
                end
                alu_ready = 1'b1;
                @(posedge clk);
                #1;
                alu_ready = 1'b0;
                alu_hs_cnt++;
                aborted = 1'b0;
                for (int d = 0; d < alu_res_delay; d++) begin
                    @(posedge clk);
                    if (!rst) aborted = 1'b1;
                end
                if (!aborted && rst) begin
                    #1;
                    alu_res       = alu_f(op0, a0, b0);
                    alu_res_valid = 1'b1;
                    @(posedge clk);
                    #1;
                    alu_res_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int e0;
        int h0;
        bit got;
        rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        #2;
        check("rst_rx_ready", 32'(rx_ready), 1);
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_alu_valid", 32'(alu_valid), 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_op", 32'(alu_op), 0);
        check("rst_err", 32'(err), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // add 1 + 2
        opv[0] = 32'd1; opv[1] = 32'd2;
        run_arith(8'hAD, 2'd0, 2);
        wait_idle();

        // mul chain 2*3*4 with slow ALU handshake
        alu_delay = 5;
        opv[0] = 32'd2; opv[1] = 32'd3; opv[2] = 32'd4;
        run_arith(8'h88, 2'd1, 3);
        wait_idle();
        alu_delay = 0;

        // empty echo, then div 100/7
        send_hdr(8'hEC, 16'd4);
        opv[0] = 32'd100; opv[1] = 32'd7;
        run_arith(8'hD1, 2'd2, 2);
        wait_idle();
        check("err_none_yet", err_cnt, 0);

        // echo with TX backpressure after the first byte
        exp_tx_q.push_back(8'h41); exp_tx_q.push_back(8'h42); exp_tx_q.push_back(8'h43);
        send_hdr(8'hEC, 16'd7);
        tx_ready = 1'b0;
        send_byte(8'h41);
        rx_data = 8'h42; rx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("echo_rx_stall", 32'(rx_ready), 0);
        end
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        send_byte(8'h42);
        send_byte(8'h43);
        wait_idle();

        // unknown opcode: drained, then a clean add
        e0 = err_cnt;
        send_byte(8'h55); send_byte(8'h00); send_byte(8'h08); send_byte(8'h00);
        check("err_after_len_opc", 32'(err), 1);
        for (int i = 0; i < 4; i++) send_byte(8'(8'hA0 + i));
        opv[0] = 32'd5; opv[1] = 32'd7;
        run_arith(8'hAD, 2'd0, 2);
        wait_idle();
        check("err_count_opc", err_cnt, e0 + 1);

        // add with a non-word length: drained, then a clean add
        send_byte(8'hAD); send_byte(8'h00); send_byte(8'h0A); send_byte(8'h00);
        check("err_after_len_arith", 32'(err), 1);
        for (int i = 0; i < 6; i++) send_byte(8'hAD);
        opv[0] = 32'h10; opv[1] = 32'h20;
        run_arith(8'hAD, 2'd0, 2);
        wait_idle();
        check("err_count_len", err_cnt, e0 + 2);

        // inter-byte timeout
        e0 = err_cnt;
        send_byte(8'hAD); send_byte(8'h00);
        k = 0; got = 1'b0;
        while (k < 100 && !got) begin
            @(negedge clk);
            k++;
            got = err;
        end
        check("timeout_idle_cycles", k - 1, 50);
        @(posedge clk);
        #1;
        check("err_count_timeout", err_cnt, e0 + 1);
        exp_tx_q.push_back(8'h11); exp_tx_q.push_back(8'h22);
        send_hdr(8'hEC, 16'd6);
        send_byte(8'h11); send_byte(8'h22);
        wait_idle();

        // reset while waiting for the ALU result
        alu_res_delay = 20;
        h0 = alu_hs_cnt;
        opv[0] = 32'd9; opv[1] = 32'd1;
        run_arith(8'hAD, 2'd0, 2);
        k = 0;
        while (alu_hs_cnt == h0 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("alu_hs_seen", 32'(alu_hs_cnt != h0), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_mid_alu_valid", 32'(alu_valid), 0);
        check("rst_mid_tx_valid", 32'(tx_valid), 0);
        check("rst_mid_rx_ready", 32'(rx_ready), 1);
        exp_tx_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        alu_res_delay = 2;
        opv[0] = 32'h0001_0000; opv[1] = 32'h20;
        run_arith(8'hAD, 2'd0, 2);
        wait_idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
